// File: rtl/player_pos_ctrl_if.sv
// Button inputs, vsync feedback and sprite coordinate outputs shared by
// player_pos_ctrl and whatever drives it.
`timescale 1ns/1ps
interface player_pos_if;
    logic        vsync;
    logic [3:0]  btn1;
    logic [3:0]  btn2;
    logic [15:0] posx;
    logic [15:0] posy;
    logic [15:0] posx2;
    logic [15:0] posy2;
    logic        frame_tick;
    logic        fast1;
    logic        fast2;

    modport master (
        output vsync, btn1, btn2,
        input  posx, posy, posx2, posy2, frame_tick, fast1, fast2
    );

    modport slave (
        input  vsync, btn1, btn2,
        output posx, posy, posx2, posy2, frame_tick, fast1, fast2
    );
endinterface

// File: rtl/player_pos_ctrl.sv
// Two-player sprite position controller: once per frame (vsync falling edge)
// each player moves with hold-to-accelerate stepping, clamped to 640x480.
//
// state | meaning
// IDLE  | no button pressed on the last tick, next move uses STEP_SLOW
// SLOW  | pressed for fewer than HOLD_FRAMES ticks, moving STEP_SLOW
// FAST  | pressed for HOLD_FRAMES or more ticks, moving STEP_FAST
`timescale 1ns/1ps
module player_pos_ctrl #(
    parameter int SIZE        = 16,
    parameter int X_MAX       = 640 - SIZE,
    parameter int Y_MAX       = 480 - SIZE,
    parameter int X1_INIT     = 100,
    parameter int Y1_INIT     = 232,
    parameter int X2_INIT     = 524,
    parameter int Y2_INIT     = 232,
    parameter int STEP_SLOW   = 1,
    parameter int STEP_FAST   = 4,
    parameter int HOLD_FRAMES = 15
) (
    input  logic dclk,
    input  logic clr,
    player_pos_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOW = 2'd1,
        ST_FAST = 2'd2
    } state_t;

    localparam int CW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam logic [15:0] STEP_S = 16'(STEP_SLOW);
    localparam logic [15:0] STEP_F = 16'(STEP_FAST);
    localparam logic [15:0] XMAX   = 16'(X_MAX);
    localparam logic [15:0] YMAX   = 16'(Y_MAX);

    // 17-bit compare so an underflow shows up as the borrow bit
    function automatic logic [15:0] dec_clamp(input logic [15:0] pos,
                                              input logic [15:0] step);
        logic [16:0] diff;
        diff = {1'b0, pos} - {1'b0, step};
        return diff[16] ? 16'd0 : diff[15:0];
    endfunction

    function automatic logic [15:0] inc_clamp(input logic [15:0] pos,
                                              input logic [15:0] step,
                                              input logic [15:0] lim);
        logic [16:0] sum;
        sum = {1'b0, pos} + {1'b0, step};
        return (sum > {1'b0, lim}) ? lim : sum[15:0];
    endfunction

    logic        vsync_q;
    logic        tick_q;
    logic [3:0]  btn_raw  [2];
    logic [15:0] pos_x    [2];
    logic [15:0] pos_y    [2];
    logic        fast     [2];

    assign btn_raw[0] = bus.btn1;
    assign btn_raw[1] = bus.btn2;

    always_ff @(posedge dclk or negedge clr) begin
        if (!clr) begin
            vsync_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            vsync_q <= bus.vsync;
            tick_q  <= vsync_q & ~bus.vsync;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_player
        localparam logic [15:0] X_INIT = (p == 0) ? 16'(X1_INIT) : 16'(X2_INIT);
        localparam logic [15:0] Y_INIT = (p == 0) ? 16'(Y1_INIT) : 16'(Y2_INIT);

        logic [3:0]    meta_q;
        logic [3:0]    sync_q;
        logic [15:0]   x_q, x_d;
        logic [15:0]   y_q, y_d;
        logic [CW-1:0] cnt_q, cnt_d;
        state_t        st_q, st_d;
        logic          fast_q;
        logic          x_act, y_act, pressed;
        logic [15:0]   step;

        always_ff @(posedge dclk or negedge clr) begin
            if (!clr) begin
                meta_q <= 4'd0;
                sync_q <= 4'd0;
            end else begin
                meta_q <= btn_raw[p];
                sync_q <= meta_q;
            end
        end

        // sync_q = {up, down, left, right}; opposing buttons cancel an axis
        always_comb begin
            y_act   = sync_q[3] ^ sync_q[2];
            x_act   = sync_q[1] ^ sync_q[0];
            pressed = x_act | y_act;
            step    = (st_q == ST_FAST) ? STEP_F : STEP_S;
            x_d     = x_q;
            y_d     = y_q;
            cnt_d   = cnt_q;
            st_d    = st_q;
            if (pressed) begin
                if (x_act) x_d = sync_q[1] ? dec_clamp(x_q, step) : inc_clamp(x_q, step, XMAX);
                if (y_act) y_d = sync_q[3] ? dec_clamp(y_q, step) : inc_clamp(y_q, step, YMAX);
                case (st_q)
                    ST_IDLE: begin
                        cnt_d = CW'(1);
                        st_d  = (HOLD_FRAMES <= 1) ? ST_FAST : ST_SLOW;
                    end
                    ST_SLOW: begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d >= CW'(HOLD_FRAMES)) st_d = ST_FAST;
                    end
                    default: begin
                        cnt_d = cnt_q;
                        st_d  = ST_FAST;
                    end
                endcase
            end else begin
                cnt_d = '0;
                st_d  = ST_IDLE;
            end
        end

        always_ff @(posedge dclk or negedge clr) begin
            if (!clr) begin
                x_q    <= X_INIT;
                y_q    <= Y_INIT;
                cnt_q  <= '0;
                st_q   <= ST_IDLE;
                fast_q <= 1'b0;
            end else if (tick_q) begin
                x_q    <= x_d;
                y_q    <= y_d;
                cnt_q  <= cnt_d;
                st_q   <= st_d;
                fast_q <= (st_d == ST_FAST);
            end
        end

        assign pos_x[p] = x_q;
        assign pos_y[p] = y_q;
        assign fast[p]  = fast_q;
    end

    assign bus.posx       = pos_x[0];
    assign bus.posy       = pos_y[0];
    assign bus.posx2      = pos_x[1];
    assign bus.posy2      = pos_y[1];
    assign bus.fast1      = fast[0];
    assign bus.fast2      = fast[1];
    assign bus.frame_tick = tick_q;

endmodule

// File: doc/player_pos_ctrl.md
Name: player_pos_ctrl

Overview:
- Upstream stage of vga640x480: turns two players' raw push-button inputs into the posx/posy/posx2/posy2 sprite coordinates that the VGA block draws.
- Updates both positions once per frame, on the falling edge of the VGA vsync it receives back. The result is tear-free motion, clamped to the visible 640x480 area.
- Each player has a hold-to-accelerate FSM: the sprite moves slowly at first and faster once the button has been held long enough.

Parameters:
- SIZE, 16, sprite edge in pixels; sets the clamp limits.
- X_MAX, 624, largest legal x (640-SIZE); the smallest legal x is 0.
- Y_MAX, 464, largest legal y (480-SIZE); the smallest legal y is 0.
- X1_INIT, 100, player-1 reset x.
- Y1_INIT, 232, player-1 reset y.
- X2_INIT, 524, player-2 reset x.
- Y2_INIT, 232, player-2 reset y.
- STEP_SLOW, 1, pixels per frame in IDLE/SLOW.
- STEP_FAST, 4, pixels per frame in FAST.
- HOLD_FRAMES, 15, consecutive pressed frames before entering FAST.

Ports:
- dclk  in  1  pixel clock (25 MHz), the same clock as vga640x480.
- clr  in  1  reset, asynchronous, active-low.
- vsync  in  1  vsync from vga640x480, active-low, synchronous to dclk.
- btn1  in  4  player-1 buttons {up,down,left,right}, asynchronous, active-high.
- btn2  in  4  player-2 buttons, same encoding as btn1.
- posx  out  16  player-1 x.
- posy  out  16  player-1 y.
- posx2  out  16  player-2 x.
- posy2  out  16  player-2 y.
- frame_tick  out  1  one-cycle pulse marking a position update.
- fast1  out  1  player-1 FSM is in FAST.
- fast2  out  1  player-2 FSM is in FAST.

Behaviour:
- Reset (clr=0, asynchronous):
  - posx=X1_INIT, posy=Y1_INIT, posx2=X2_INIT, posy2=Y2_INIT.
  - frame_tick=0, fast1=fast2=0.
  - Both FSMs go to IDLE and both hold counters clear to 0.
  - All synchronizer flops and vsync_q are set to 1 (vsync_q) / 0 (button flops), so no spurious tick or press follows reset release.
- Button synchronization: each button bit passes through a 2-flop synchronizer. The FSM and position logic see only the synchronized values (s1/s2).
- Frame tick:
  - vsync_q is vsync registered once.
  - frame_tick is registered high in cycle N+1 when cycle N has vsync_q=1 and vsync=0. It is exactly one cycle wide per falling edge.
  - A vsync held low produces no further ticks.
- Update timing: positions, FSMs and counters change only at the clock edge that ends the frame_tick cycle. They use the synchronized buttons sampled in that cycle, so new positions are visible two cycles after the vsync falling edge. Between ticks all outputs hold.
- Effective direction, per axis:
  - up and down both pressed: the y axis is cancelled.
  - left and right both pressed: the x axis is cancelled.
  - The player counts as "pressed" if at least one axis is uncancelled.
- Step size: taken from the state before the update. IDLE/SLOW use STEP_SLOW; FAST uses STEP_FAST.
- FSM transitions, evaluated per player on each tick:
  - IDLE + pressed: move, cnt=1, go to SLOW, or directly to FAST if HOLD_FRAMES==1.
  - SLOW + pressed: move, cnt=cnt+1. When cnt+1==HOLD_FRAMES, go to FAST.
  - FAST + pressed: move, stay in FAST; cnt saturates.
  - Any state + not pressed: no move, go to IDLE, cnt=0.
- Movement is diagonal when both axes are active; each axis moves by the full step.
- Clamp arithmetic: done at 17 bits, unsigned with borrow.
  - Decrement: if pos < step, result is 0; else pos-step.
  - Increment: if pos+step > MAX, result is MAX; else pos+step.
  - A coordinate already at a limit and pushed further stays put. The FSM still advances, because a pushed button counts as pressed.
- fast1/fast2 are 1 exactly while the corresponding FSM is in FAST.
- The two players are fully independent. The sprites may overlap; collisions are handled downstream.
- Reset asserted mid-frame or mid-hold forces the reset values immediately; no tick is lost or duplicated afterward.

Test Plan:
- Reset: clr=0 then 1, no buttons, 3 vsync falls -> posx=100, posy=232, posx2=524, posy2=232, fast1=fast2=0, exactly 3 frame_tick pulses, each 1 cycle wide.
- Slow move: btn1=right held for 5 frames -> posx=105, posy unchanged, fast1=0; frame_tick asserts 1 cycle after the vsync falling edge and posx changes on the following edge.
- Acceleration: btn2=up held for 20 frames -> 15 slow frames plus 5 fast frames give posy2 = 232-15-20 = 197, fast2 rises after the 15th tick; releasing for 1 frame -> fast2=0 and posy2 holds.
- Clamp at the low limit: posx=2 with btn1=left in FAST -> posx=0 and stays 0 on further frames. Clamp at the high limit: posy2 at 462, down in FAST -> 464.
- Cancel and diagonal: btn1=up+down+right for 1 frame -> posx+1, posy unchanged. btn1=up+down+left+right -> no move, FSM returns to IDLE.
- Async reset mid-hold: player 1 in FAST at posx=300, clr pulsed low for 1 cycle between ticks -> posx=100 and fast1=0 immediately; next press restarts at STEP_SLOW.
